// File: rtl/functional_unit_seq_if.sv
// -----------------------------------------------------------------------------
// functional_unit_seq_if
//   Handshake bundle between the register-file read stage (master side) and
//   the sequential functional unit (slave side).
//
//   Request channel  : in_valid / in_ready, operands inS / inT, function FS
//   Response channel : out_valid / out_ready, result F, flags V C N Z,
//                      out_err (illegal function select)
//
//   Parameter WIDTH  : operand/result width (power of two, >= 4)
// -----------------------------------------------------------------------------
interface functional_unit_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] inS;
    logic [WIDTH-1:0] inT;
    logic [3:0]       FS;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] F;
    logic             V;
    logic             C;
    logic             N;
    logic             Z;
    logic             out_err;

    // Producer of operations and consumer of results
    modport master (
        output in_valid, inS, inT, FS, out_ready,
        input  in_ready, out_valid, F, V, C, N, Z, out_err
    );

    // The functional unit itself
    modport slave (
        input  in_valid, inS, inT, FS, out_ready,
        output in_ready, out_valid, F, V, C, N, Z, out_err
    );
endinterface

// File: rtl/functional_unit_seq.sv
// -----------------------------------------------------------------------------
// functional_unit_seq
//   Handshaked ALU: accepts one operation per valid/ready transaction, computes
//   a WIDTH-bit result plus V/C/N/Z flags and holds them on the output channel
//   until the consumer takes them.  Variable shifts run one bit per cycle; the
//   optional multiplier is a shift-add engine retiring one multiplier bit per
//   cycle.
//
//   FS: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(inS), 6 SLA, 7 SRA, 8 SRL,
//       9 MUL (only with FU_MUL_EN), everything else illegal (out_err=1).
//
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     bus    - functional_unit_seq_if.slave (request + response channels)
//
//   Build option:
//     FU_MUL_EN - when defined, compiles in the MUL state and shift-add
//                 multiplier; otherwise FS=9 is treated as illegal.
// -----------------------------------------------------------------------------
module functional_unit_seq #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    functional_unit_seq_if.slave  bus
);

    // One extra bit so the multiplier can count WIDTH iterations
    localparam int CNT_W = SHAMT_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [3:0] FS_ADD = 4'd0;
    localparam logic [3:0] FS_SUB = 4'd1;
    localparam logic [3:0] FS_AND = 4'd2;
    localparam logic [3:0] FS_OR  = 4'd3;
    localparam logic [3:0] FS_XOR = 4'd4;
    localparam logic [3:0] FS_NOT = 4'd5;
    localparam logic [3:0] FS_SLA = 4'd6;
    localparam logic [3:0] FS_SRA = 4'd7;
    localparam logic [3:0] FS_SRL = 4'd8;
    localparam logic [3:0] FS_MUL = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
`ifdef FU_MUL_EN
        ST_MUL   = 2'd3,
`endif
        ST_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] f;
        logic             v;
        logic             c;
        logic             err;
    } res_t;

    typedef struct packed {
        logic [WIDTH-1:0] val;
        logic             bit_out;
        logic             chg;
    } step_t;

    function automatic logic is_shift(input logic [3:0] fs);
        return (fs == FS_SLA) || (fs == FS_SRA) || (fs == FS_SRL);
    endfunction

    // Everything that completes in the accept cycle: logic/arith ops,
    // zero-amount shifts and illegal codes.
    function automatic res_t single_op(input logic [3:0]       fs,
                                       input logic [WIDTH-1:0] s,
                                       input logic [WIDTH-1:0] t);
        res_t           r;
        logic [WIDTH:0] wide;
        r    = '{f: {WIDTH{1'b0}}, v: 1'b0, c: 1'b0, err: 1'b0};
        wide = {(WIDTH+1){1'b0}};
        case (fs)
            FS_ADD: begin
                wide = {1'b0, s} + {1'b0, t};
                r.f  = wide[WIDTH-1:0];
                r.c  = wide[WIDTH];
                r.v  = (s[WIDTH-1] == t[WIDTH-1]) && (wide[WIDTH-1] != s[WIDTH-1]);
            end
            FS_SUB: begin
                // MSB of the extended difference is the unsigned borrow
                wide = {1'b0, s} - {1'b0, t};
                r.f  = wide[WIDTH-1:0];
                r.c  = wide[WIDTH];
                r.v  = (s[WIDTH-1] != t[WIDTH-1]) && (wide[WIDTH-1] != s[WIDTH-1]);
            end
            FS_AND: r.f = s & t;
            FS_OR:  r.f = s | t;
            FS_XOR: r.f = s ^ t;
            FS_NOT: r.f = ~s;
            // Only zero-amount shifts arrive here: value passes, C=V=0
            FS_SLA, FS_SRA, FS_SRL: r.f = s;
            // Reached only when the multiplier is not compiled in
            FS_MUL: r.err = 1'b1;
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    // One single-bit shift step; chg flags an MSB change (SLA overflow)
    function automatic step_t shift_step(input logic [3:0]       fs,
                                         input logic [WIDTH-1:0] v);
        step_t st;
        st = '{val: v, bit_out: 1'b0, chg: 1'b0};
        case (fs)
            FS_SLA: begin
                st.val     = {v[WIDTH-2:0], 1'b0};
                st.bit_out = v[WIDTH-1];
                st.chg     = v[WIDTH-1] ^ v[WIDTH-2];
            end
            FS_SRA: begin
                st.val     = {v[WIDTH-1], v[WIDTH-1:1]};
                st.bit_out = v[0];
            end
            FS_SRL: begin
                st.val     = {1'b0, v[WIDTH-1:1]};
                st.bit_out = v[0];
            end
            default: st.val = v;
        endcase
        return st;
    endfunction

    state_t             state_r,  state_nxt_s;
    logic [3:0]         op_r,     op_nxt_s;
    logic [WIDTH-1:0]   work_r,   work_nxt_s;
    logic               vacc_r,   vacc_nxt_s;
    logic [CNT_W-1:0]   cnt_r,    cnt_nxt_s;
    logic [WIDTH-1:0]   f_r,      f_nxt_s;
    logic               v_r,      v_nxt_s;
    logic               c_r,      c_nxt_s;
    logic               n_r,      n_nxt_s;
    logic               z_r,      z_nxt_s;
    logic               err_r,    err_nxt_s;
`ifdef FU_MUL_EN
    logic [2*WIDTH-1:0] prod_r,   prod_nxt_s;
    logic [WIDTH-1:0]   mcand_r,  mcand_nxt_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_prod_s;
`endif

    logic               in_ready_s;
    logic               acc_s;
    logic [SHAMT_W-1:0] amt_s;
    res_t               res_s;
    res_t               fin_s;
    logic               load_s;
    step_t              step_s;

    // A new op may enter when idle, or when the held result leaves this cycle
    assign in_ready_s = (state_r == ST_IDLE) || ((state_r == ST_DONE) && bus.out_ready);
    assign acc_s      = bus.in_valid && in_ready_s;
    assign amt_s      = bus.inT[SHAMT_W-1:0];
    assign res_s      = single_op(bus.FS, bus.inS, bus.inT);
    assign step_s     = shift_step(op_r, work_r);

`ifdef FU_MUL_EN
    // prod_r holds {partial sum, remaining multiplier bits}; each cycle adds
    // the multiplicand when the multiplier LSB is set, then shifts right.
    assign mul_sum_s  = {1'b0, prod_r[2*WIDTH-1:WIDTH]}
                      + (prod_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    assign mul_prod_s = {mul_sum_s, prod_r[WIDTH-1:1]};
`endif

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = (state_r == ST_DONE);
    assign bus.F         = f_r;
    assign bus.V         = v_r;
    assign bus.C         = c_r;
    assign bus.N         = n_r;
    assign bus.Z         = z_r;
    assign bus.out_err   = err_r;

    // Next-state and datapath update for the sequencer
    always_comb begin
        state_nxt_s = state_r;
        op_nxt_s    = op_r;
        work_nxt_s  = work_r;
        vacc_nxt_s  = vacc_r;
        cnt_nxt_s   = cnt_r;
`ifdef FU_MUL_EN
        prod_nxt_s  = prod_r;
        mcand_nxt_s = mcand_r;
`endif
        load_s      = 1'b0;
        fin_s       = '{f: {WIDTH{1'b0}}, v: 1'b0, c: 1'b0, err: 1'b0};

        if (acc_s) begin
            op_nxt_s = bus.FS;
            if (is_shift(bus.FS) && (amt_s != {SHAMT_W{1'b0}})) begin
                state_nxt_s = ST_SHIFT;
                work_nxt_s  = bus.inS;
                vacc_nxt_s  = 1'b0;
                cnt_nxt_s   = {1'b0, amt_s};
            end
`ifdef FU_MUL_EN
            else if (bus.FS == FS_MUL) begin
                state_nxt_s = ST_MUL;
                prod_nxt_s  = {{WIDTH{1'b0}}, bus.inT};
                mcand_nxt_s = bus.inS;
                cnt_nxt_s   = CNT_W'(WIDTH);
            end
`endif
            else begin
                state_nxt_s = ST_DONE;
                load_s      = 1'b1;
                fin_s       = res_s;
            end
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = ST_IDLE;
                ST_SHIFT: begin
                    work_nxt_s = step_s.val;
                    vacc_nxt_s = vacc_r | ((op_r == FS_SLA) & step_s.chg);
                    cnt_nxt_s  = cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_nxt_s = ST_DONE;
                        load_s      = 1'b1;
                        fin_s.f     = step_s.val;
                        fin_s.c     = step_s.bit_out;
                        fin_s.v     = vacc_nxt_s;
                        fin_s.err   = 1'b0;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end
`ifdef FU_MUL_EN
                ST_MUL: begin
                    prod_nxt_s = mul_prod_s;
                    cnt_nxt_s  = cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_nxt_s = ST_DONE;
                        load_s      = 1'b1;
                        fin_s.f     = mul_prod_s[WIDTH-1:0];
                        fin_s.c     = |mul_prod_s[2*WIDTH-1:WIDTH];
                        fin_s.v     = 1'b0;
                        fin_s.err   = 1'b0;
                    end else begin
                        state_nxt_s = ST_MUL;
                    end
                end
`endif
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Result/flag registers change only when an operation completes
    always_comb begin
        f_nxt_s   = f_r;
        v_nxt_s   = v_r;
        c_nxt_s   = c_r;
        n_nxt_s   = n_r;
        z_nxt_s   = z_r;
        err_nxt_s = err_r;
        if (load_s) begin
            f_nxt_s   = fin_s.f;
            v_nxt_s   = fin_s.v;
            c_nxt_s   = fin_s.c;
            n_nxt_s   = fin_s.f[WIDTH-1];
            z_nxt_s   = (fin_s.f == {WIDTH{1'b0}});
            err_nxt_s = fin_s.err;
        end else begin
            f_nxt_s   = f_r;
            err_nxt_s = err_r;
        end
    end

    // State and datapath registers; reset abandons any op in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            op_r    <= 4'd0;
            work_r  <= {WIDTH{1'b0}};
            vacc_r  <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            f_r     <= {WIDTH{1'b0}};
            v_r     <= 1'b0;
            c_r     <= 1'b0;
            n_r     <= 1'b0;
            z_r     <= 1'b0;
            err_r   <= 1'b0;
`ifdef FU_MUL_EN
            prod_r  <= {(2*WIDTH){1'b0}};
            mcand_r <= {WIDTH{1'b0}};
`endif
        end else begin
            state_r <= state_nxt_s;
            op_r    <= op_nxt_s;
            work_r  <= work_nxt_s;
            vacc_r  <= vacc_nxt_s;
            cnt_r   <= cnt_nxt_s;
            f_r     <= f_nxt_s;
            v_r     <= v_nxt_s;
            c_r     <= c_nxt_s;
            n_r     <= n_nxt_s;
            z_r     <= z_nxt_s;
            err_r   <= err_nxt_s;
`ifdef FU_MUL_EN
            prod_r  <= prod_nxt_s;
            mcand_r <= mcand_nxt_s;
`endif
        end
    end

endmodule
